mem_access_sequencer: RTL and testbench
=======================================

// Module: mem_access_sequencer
// PURPOSE
// - Sits between the EX/MEM pipeline register and memory_stage; turns one memory request per instruction into
//   memory_stage strobes (read/write/push/pop) and sequences the multi-word ops CALL/RET/INT/RTI.
// - Captures read/pop data into result/PC/flag registers for writeback and fetch.
// - Stalls upstream while a multi-cycle op is in flight.
// PARAMETERS
// - ADDR_W  16  data-memory address width
// - DATA_W  16  memory word width
// - PC_W    32  program counter width (two memory words)
// - FLAG_W  3   CCR flag width saved by INT / restored by RTI
// PORTS
// - clk           in   1       clock, rising edge
// - rst           in   1       asynchronous, active-high reset
// - req_valid     in   1       request present this cycle
// - req_op        in   3       0 NONE,1 LOAD,2 STORE,3 PUSH,4 POP,5 CALL,6 RET,7 INT(+RTI via req_rti)
// - req_rti       in   1       with req_op==7: RTI instead of INT
// - req_addr      in   ADDR_W  LOAD/STORE address
// - req_wdata     in   DATA_W  STORE/PUSH data
// - req_pc        in   PC_W    return address for CALL/INT
// - req_flags     in   FLAG_W  flags saved by INT
// - memory_read, memory_write, memory_push, memory_pop   out 1 each   strobes to memory_stage
// - mem_address   out  ADDR_W  to memory_stage address
// - mem_wdata     out  DATA_W  to memory_stage write_data
// - mem_rdata     in   DATA_W  memory_stage data (valid same cycle as read/pop strobe)
// - stall         out  1       upstream must hold its request next cycle
// - result_valid  out  1       1-cycle pulse: result_data holds LOAD/POP data
// - result_data   out  DATA_W  registered LOAD/POP data
// - pc_load       out  1       1-cycle pulse: pc_out valid (RET/RTI)
// - pc_out        out  PC_W    restored PC
// - flags_load    out  1       1-cycle pulse: flags_out valid (RTI)
// - flags_out     out  FLAG_W  restored flags
// BEHAVIOUR
// - Reset: state IDLE; all strobes, stall, result_valid, pc_load, flags_load = 0; result_data, pc_out, flags_out = 0.
// - Strobes, mem_address and mem_wdata are combinational from state + request; at most one strobe high per cycle.
// - Requests are sampled only in IDLE. Any request presented while not IDLE is ignored.
// - LOAD/STORE/PUSH/POP: one cycle, stall=0.
//   LOAD: memory_read, mem_address=req_addr; mem_rdata registered at the edge, result_valid pulses next cycle.
//   STORE: memory_write. PUSH: memory_push, mem_wdata=req_wdata. POP: memory_pop, result as for LOAD.
// - CALL: IDLE push pc[31:16] -> CALL_LO push pc[15:0] -> IDLE. stall=1 in the IDLE accept cycle only.
// - INT: IDLE push pc[31:16] -> INT_LO push pc[15:0] -> INT_FLG push {0,flags} -> IDLE.
//   stall=1 in the accept cycle and in INT_LO.
// - RET: IDLE pop -> pc_lo reg; RET_HI pop -> pc_out={mem_rdata,pc_lo}; pc_load pulses the cycle after RET_HI.
//   stall=1 in the accept cycle.
// - RTI: IDLE pop flags -> RTI_LO pop pc_lo -> RTI_HI pop pc_hi.
//   flags_load and pc_load pulse together the cycle after RTI_HI. stall=1 in the accept cycle and in RTI_LO.
// - Stall rule: stall=1 exactly when the next state is not IDLE. Upstream holds its request while stall=1;
//   its next op is accepted in the cycle after the final state.
// - req_pc, req_flags are latched at accept; later changes do not affect the sequence.
// - Data widths: flags zero-extended to DATA_W on push; truncated to FLAG_W on pop.
// - req_op NONE or req_valid=0: no strobe, no pulse.
// - Reset mid-sequence: immediate return to IDLE. Words already pushed/popped stay as done (SP not repaired).
//   No pc_load/flags_load is issued.
// - Stack order is fixed: high word pushed first. RET/RTI pop in exact reverse order.
// STRUCTURE
// - Shared package mem_seq_pkg holds:
//   - op codes OP_NONE..OP_INT;
//   - state enum IDLE, CALL_LO, INT_LO, INT_FLG, RET_HI, RTI_LO, RTI_HI;
//   - width constants.
// - Single module: one state register, latched pc/flags registers, output pulse registers. No sub-module.
// TESTING
// - Reset, then LOAD addr 0x0010 with mem[0x10]=0xBEEF -> memory_read 1 cycle, stall 0;
//   next cycle result_valid=1, result_data=0xBEEF.
// - CALL pc=0x0001_2345 -> push 0x0001 then 0x2345 on consecutive cycles; stall=1 only in cycle 1;
//   next STORE accepted in cycle 3.
// - Back-to-back: CALL 0x0001_2345 then RET -> pops 0x2345, 0x0001; pc_load pulse, pc_out=0x0001_2345.
// - INT pc=0x0000_0100 flags=3'b101 then RTI -> three pushes (0x0000, 0x0100, 0x0005), three pops;
//   flags_out=3'b101 and pc_out=0x0000_0100 with simultaneous pulses.
// - Assert rst during INT_LO -> all strobes 0 same cycle, state IDLE; stack holds only 0x0000;
//   no pc_load or flags_load afterwards.
// - Change req_op/req_pc while stall=1 -> no effect on the strobe sequence or pushed values.

Source files
------------

// File: rtl/mem_access_sequencer_pkg.sv
// Shared types for the memory access sequencer: request op codes, sequencer states, default widths.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package mem_seq_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_PC_W   = 32;  // two memory words, high word pushed first
  localparam int DEF_FLAG_W = 3;

  // Encoding of req_op; OP_INT doubles as RTI when req_rti is set.
  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_LOAD  = 3'd1,
    OP_STORE = 3'd2,
    OP_PUSH  = 3'd3,
    OP_POP   = 3'd4,
    OP_CALL  = 3'd5,
    OP_RET   = 3'd6,
    OP_INT   = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CALL_LO = 3'd1,
    INT_LO  = 3'd2,
    INT_FLG = 3'd3,
    RET_HI  = 3'd4,
    RTI_LO  = 3'd5,
    RTI_HI  = 3'd6
  } state_e;

  // Zero-extend CCR flags to a full memory word for the stack push.
  function automatic logic [DEF_DATA_W-1:0] flags_to_word(input logic [DEF_FLAG_W-1:0] f);
    return {{(DEF_DATA_W-DEF_FLAG_W){1'b0}}, f};
  endfunction

endpackage

// File: rtl/mem_access_sequencer_if.sv
// Bundle between EX/MEM request source, the sequencer, memory_stage and writeback/fetch consumers.
// Latency: n/a (wires only).
// Backpressure: stall is driven by the sequencer; the request side must hold its request while it is high.
// Ports: req_* (request in), memory_* / mem_* (memory_stage strobes, address, data),
//        stall, result_*, pc_*, flags_* (writeback / fetch results).
interface mem_access_sequencer_if
  import mem_seq_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int PC_W   = DEF_PC_W,
  parameter int FLAG_W = DEF_FLAG_W
);
  // request side
  logic              req_valid;
  logic [2:0]        req_op;
  logic              req_rti;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [PC_W-1:0]   req_pc;
  logic [FLAG_W-1:0] req_flags;
  logic              stall;
  // memory_stage side
  logic              memory_read;
  logic              memory_write;
  logic              memory_push;
  logic              memory_pop;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  // writeback / fetch side
  logic              result_valid;
  logic [DATA_W-1:0] result_data;
  logic              pc_load;
  logic [PC_W-1:0]   pc_out;
  logic              flags_load;
  logic [FLAG_W-1:0] flags_out;

  // master: the sequencer itself
  modport master (
    input  req_valid, req_op, req_rti, req_addr, req_wdata, req_pc, req_flags, mem_rdata,
    output stall, memory_read, memory_write, memory_push, memory_pop, mem_address, mem_wdata,
           result_valid, result_data, pc_load, pc_out, flags_load, flags_out
  );

  // slave: the surrounding pipeline / memory_stage
  modport slave (
    output req_valid, req_op, req_rti, req_addr, req_wdata, req_pc, req_flags, mem_rdata,
    input  stall, memory_read, memory_write, memory_push, memory_pop, mem_address, mem_wdata,
           result_valid, result_data, pc_load, pc_out, flags_load, flags_out
  );

endinterface

// File: rtl/mem_access_sequencer.sv
// Turns one EX/MEM memory request into memory_stage strobes; sequences CALL/RET/INT/RTI over the stack.
// Latency: strobes combinational in the accept cycle; result/pc/flags pulses one cycle after the last strobe.
// Backpressure: stall high exactly when the next state is not IDLE; requests seen outside IDLE are ignored.
// Ports: clk, rst (async active-high); bus (master modport): req_* in, memory_* strobes, mem_address,
//        mem_wdata out, mem_rdata in, stall out, result_valid/result_data, pc_load/pc_out, flags_load/flags_out.
module mem_access_sequencer
  import mem_seq_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int PC_W   = DEF_PC_W,
  parameter int FLAG_W = DEF_FLAG_W
) (
  input  logic                   clk,
  input  logic                   rst,
  mem_access_sequencer_if.master bus
);

  state_e            state_q,        state_d;
  logic [PC_W-1:0]   pc_q,           pc_d;          // return PC latched at accept
  logic [FLAG_W-1:0] flags_q,        flags_d;       // INT: flags to push; RTI: flags popped first
  logic [DATA_W-1:0] pc_lo_q,        pc_lo_d;       // low PC word popped by RET/RTI
  logic              result_valid_q, result_valid_d;
  logic [DATA_W-1:0] result_data_q,  result_data_d;
  logic              pc_load_q,      pc_load_d;
  logic [PC_W-1:0]   pc_out_q,       pc_out_d;
  logic              flags_load_q,   flags_load_d;
  logic [FLAG_W-1:0] flags_out_q,    flags_out_d;

  logic              rd, wr, psh, pp;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              accept;

  // Gating with rst keeps every strobe low while reset is held, even if a request is presented.
  assign accept = bus.req_valid && !rst;

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    flags_d        = flags_q;
    pc_lo_d        = pc_lo_q;
    result_valid_d = 1'b0;
    result_data_d  = result_data_q;
    pc_load_d      = 1'b0;
    pc_out_d       = pc_out_q;
    flags_load_d   = 1'b0;
    flags_out_d    = flags_out_q;
    rd             = 1'b0;
    wr             = 1'b0;
    psh            = 1'b0;
    pp             = 1'b0;
    addr           = '0;
    wdata          = '0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          unique case (op_e'(bus.req_op))
            OP_LOAD: begin
              rd             = 1'b1;
              addr           = bus.req_addr;
              result_valid_d = 1'b1;
              result_data_d  = bus.mem_rdata;
            end
            OP_STORE: begin
              wr    = 1'b1;
              addr  = bus.req_addr;
              wdata = bus.req_wdata;
            end
            OP_PUSH: begin
              psh   = 1'b1;
              wdata = bus.req_wdata;
            end
            OP_POP: begin
              pp             = 1'b1;
              result_valid_d = 1'b1;
              result_data_d  = bus.mem_rdata;
            end
            OP_CALL: begin
              psh     = 1'b1;
              wdata   = bus.req_pc[PC_W-1 -: DATA_W];
              pc_d    = bus.req_pc;
              state_d = CALL_LO;
            end
            OP_RET: begin
              pp      = 1'b1;
              pc_lo_d = bus.mem_rdata;
              state_d = RET_HI;
            end
            OP_INT: begin
              if (bus.req_rti) begin
                // RTI pops in reverse of INT: flags first, then PC low, then PC high.
                pp      = 1'b1;
                flags_d = bus.mem_rdata[FLAG_W-1:0];
                state_d = RTI_LO;
              end else begin
                psh     = 1'b1;
                wdata   = bus.req_pc[PC_W-1 -: DATA_W];
                pc_d    = bus.req_pc;
                flags_d = bus.req_flags;
                state_d = INT_LO;
              end
            end
            default: ;  // OP_NONE: nothing to do
          endcase
        end
      end
      CALL_LO: begin
        psh     = 1'b1;
        wdata   = pc_q[DATA_W-1:0];
        state_d = IDLE;
      end
      INT_LO: begin
        psh     = 1'b1;
        wdata   = pc_q[DATA_W-1:0];
        state_d = INT_FLG;
      end
      INT_FLG: begin
        psh     = 1'b1;
        wdata   = flags_to_word(flags_q);
        state_d = IDLE;
      end
      RET_HI: begin
        pp        = 1'b1;
        pc_out_d  = {bus.mem_rdata, pc_lo_q};
        pc_load_d = 1'b1;
        state_d   = IDLE;
      end
      RTI_LO: begin
        pp      = 1'b1;
        pc_lo_d = bus.mem_rdata;
        state_d = RTI_HI;
      end
      RTI_HI: begin
        pp           = 1'b1;
        pc_out_d     = {bus.mem_rdata, pc_lo_q};
        pc_load_d    = 1'b1;
        flags_out_d  = flags_q;
        flags_load_d = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      pc_q           <= '0;
      flags_q        <= '0;
      pc_lo_q        <= '0;
      result_valid_q <= 1'b0;
      result_data_q  <= '0;
      pc_load_q      <= 1'b0;
      pc_out_q       <= '0;
      flags_load_q   <= 1'b0;
      flags_out_q    <= '0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      flags_q        <= flags_d;
      pc_lo_q        <= pc_lo_d;
      result_valid_q <= result_valid_d;
      result_data_q  <= result_data_d;
      pc_load_q      <= pc_load_d;
      pc_out_q       <= pc_out_d;
      flags_load_q   <= flags_load_d;
      flags_out_q    <= flags_out_d;
    end
  end

  assign bus.memory_read  = rd;
  assign bus.memory_write = wr;
  assign bus.memory_push  = psh;
  assign bus.memory_pop   = pp;
  assign bus.mem_address  = addr;
  assign bus.mem_wdata    = wdata;
  assign bus.stall        = (state_d != IDLE);
  assign bus.result_valid = result_valid_q;
  assign bus.result_data  = result_data_q;
  assign bus.pc_load      = pc_load_q;
  assign bus.pc_out       = pc_out_q;
  assign bus.flags_load   = flags_load_q;
  assign bus.flags_out    = flags_out_q;

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Directed bench for mem_access_sequencer with a stack/data memory model and strobe/result scoreboards.
// Latency: n/a.
// Backpressure: n/a.
module tb_mem_access_sequencer;
  import mem_seq_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_access_sequencer_if bus ();
  mem_access_sequencer dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask

  // ---------------- memory_stage model ----------------
  logic [15:0] dmem [0:65535];
  logic [15:0] stk [$];
  logic [15:0] stk_top = 16'h0;

  assign bus.mem_rdata = bus.memory_pop ? stk_top :
                         (bus.memory_read ? dmem[bus.mem_address] : 16'h0);

  always @(posedge clk) begin
    if (bus.memory_write) dmem[bus.mem_address] <= bus.mem_wdata;
    if (bus.memory_push) begin
      stk.push_back(bus.mem_wdata);
      stk_top <= bus.mem_wdata;
    end
    if (bus.memory_pop && stk.size() != 0) begin
      void'(stk.pop_back());
      stk_top <= (stk.size() != 0) ? stk[$] : 16'h0;
    end
  end

  // ---------------- scoreboards ----------------
  typedef struct {
    logic [3:0]  kind;  // {read, write, push, pop}
    logic [15:0] addr;
    logic [15:0] data;
    bit          chk_addr;
    bit          chk_data;
  } strb_t;

  typedef struct {
    bit          is_result;
    bit          has_pc;
    bit          has_flags;
    logic [15:0] data;
    logic [31:0] pc;
    logic [2:0]  flags;
  } out_t;

  strb_t exp_s [$];
  out_t  exp_o [$];

  task automatic exp_read(input logic [15:0] a);
    exp_s.push_back('{4'b1000, a, 16'h0, 1'b1, 1'b0});
  endtask
  task automatic exp_write(input logic [15:0] a, input logic [15:0] d);
    exp_s.push_back('{4'b0100, a, d, 1'b1, 1'b1});
  endtask
  task automatic exp_push(input logic [15:0] d);
    exp_s.push_back('{4'b0010, 16'h0, d, 1'b0, 1'b1});
  endtask
  task automatic exp_pop();
    exp_s.push_back('{4'b0001, 16'h0, 16'h0, 1'b0, 1'b0});
  endtask
  task automatic exp_result(input logic [15:0] d);
    exp_o.push_back('{1'b1, 1'b0, 1'b0, d, 32'h0, 3'h0});
  endtask
  task automatic exp_pc(input logic [31:0] pc);
    exp_o.push_back('{1'b0, 1'b1, 1'b0, 16'h0, pc, 3'h0});
  endtask
  task automatic exp_pc_flags(input logic [31:0] pc, input logic [2:0] f);
    exp_o.push_back('{1'b0, 1'b1, 1'b1, 16'h0, pc, f});
  endtask

  logic [3:0] mon_s;
  strb_t      mon_es;
  out_t       mon_eo;

  always @(negedge clk) begin
    mon_s = {bus.memory_read, bus.memory_write, bus.memory_push, bus.memory_pop};
    chk("strobe_onehot", 32'($countones(mon_s) <= 1), 1);
    if (mon_s != 4'b0) begin
      chk("strobe_expected", 32'(exp_s.size() != 0), 1);
      if (exp_s.size() != 0) begin
        mon_es = exp_s.pop_front();
        chk("strobe_kind", 32'(mon_s), 32'(mon_es.kind));
        if (mon_es.chk_addr) chk("strobe_addr", 32'(bus.mem_address), 32'(mon_es.addr));
        if (mon_es.chk_data) chk("strobe_wdata", 32'(bus.mem_wdata), 32'(mon_es.data));
      end
    end
    if (bus.result_valid || bus.pc_load || bus.flags_load) begin
      chk("pulse_expected", 32'(exp_o.size() != 0), 1);
      if (exp_o.size() != 0) begin
        mon_eo = exp_o.pop_front();
        chk("pulse_result_valid", 32'(bus.result_valid), 32'(mon_eo.is_result));
        chk("pulse_pc_load", 32'(bus.pc_load), 32'(mon_eo.has_pc));
        chk("pulse_flags_load", 32'(bus.flags_load), 32'(mon_eo.has_flags));
        if (mon_eo.is_result) chk("result_data", 32'(bus.result_data), 32'(mon_eo.data));
        if (mon_eo.has_pc) chk("pc_out", bus.pc_out, mon_eo.pc);
        if (mon_eo.has_flags) chk("flags_out", 32'(bus.flags_out), 32'(mon_eo.flags));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input op_e op, input logic rti, input logic [15:0] a,
                       input logic [15:0] d, input logic [31:0] pc, input logic [2:0] f);
    bus.req_valid = v;
    bus.req_op    = op;
    bus.req_rti   = rti;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.req_pc    = pc;
    bus.req_flags = f;
  endtask

  task automatic idle();
    drive(1'b0, OP_NONE, 1'b0, 16'h0, 16'h0, 32'h0, 3'h0);
  endtask

  int stk_before;

  initial begin
    rst = 1'b1;
    idle();
    for (int i = 0; i < 65536; i++) dmem[i] = 16'(i * 3);
    dmem[16'h0010] = 16'hBEEF;
    repeat (2) cyc();

    // reset state
    chk("rst_strobes", 32'({bus.memory_read, bus.memory_write, bus.memory_push, bus.memory_pop}), 0);
    chk("rst_stall", 32'(bus.stall), 0);
    chk("rst_pulses", 32'({bus.result_valid, bus.pc_load, bus.flags_load}), 0);
    chk("rst_result_data", 32'(bus.result_data), 0);
    chk("rst_pc_out", bus.pc_out, 0);
    chk("rst_flags_out", 32'(bus.flags_out), 0);
    rst = 1'b0;
    cyc();

    // LOAD 0x0010 -> 0xBEEF next cycle
    drive(1'b1, OP_LOAD, 1'b0, 16'h0010, 16'h0, 32'h0, 3'h0);
    exp_read(16'h0010);
    exp_result(16'hBEEF);
    #1;
    chk("load_stall", 32'(bus.stall), 0);
    chk("load_read", 32'(bus.memory_read), 1);
    cyc();
    idle();
    #1;
    chk("load_result_valid", 32'(bus.result_valid), 1);
    chk("load_result_data", 32'(bus.result_data), 32'hBEEF);
    cyc();

    // PUSH then POP round trip
    drive(1'b1, OP_PUSH, 1'b0, 16'h0, 16'h1234, 32'h0, 3'h0);
    exp_push(16'h1234);
    cyc();
    drive(1'b1, OP_POP, 1'b0, 16'h0, 16'h0, 32'h0, 3'h0);
    exp_pop();
    exp_result(16'h1234);
    #1;
    chk("pop_stall", 32'(bus.stall), 0);
    cyc();
    idle();
    cyc();

    // CALL 0x0001_2345, later-changed request ignored, STORE accepted in cycle 3
    drive(1'b1, OP_CALL, 1'b0, 16'h0, 16'h0, 32'h0001_2345, 3'h0);
    exp_push(16'h0001);
    exp_push(16'h2345);
    #1;
    chk("call_c1_stall", 32'(bus.stall), 1);
    cyc();
    drive(1'b1, OP_LOAD, 1'b0, 16'h0010, 16'h0, 32'hDEAD_BEEF, 3'h0);
    #1;
    chk("call_c2_stall", 32'(bus.stall), 0);
    chk("call_c2_push", 32'(bus.memory_push), 1);
    cyc();
    drive(1'b1, OP_STORE, 1'b0, 16'h0020, 16'h5A5A, 32'h0, 3'h0);
    exp_write(16'h0020, 16'h5A5A);
    #1;
    chk("store_c3_write", 32'(bus.memory_write), 1);
    cyc();
    idle();
    cyc();
    chk("store_mem", 32'(dmem[16'h0020]), 32'h5A5A);

    // CALL then RET back to back
    drive(1'b1, OP_CALL, 1'b0, 16'h0, 16'h0, 32'h0001_2345, 3'h0);
    exp_push(16'h0001);
    exp_push(16'h2345);
    cyc();
    cyc();
    drive(1'b1, OP_RET, 1'b0, 16'h0, 16'h0, 32'h0, 3'h0);
    exp_pop();
    exp_pop();
    exp_pc(32'h0001_2345);
    #1;
    chk("ret_c1_stall", 32'(bus.stall), 1);
    chk("ret_c1_rdata", 32'(bus.mem_rdata), 32'h2345);
    cyc();
    #1;
    chk("ret_c2_stall", 32'(bus.stall), 0);
    chk("ret_c2_rdata", 32'(bus.mem_rdata), 32'h0001);
    cyc();
    idle();
    #1;
    chk("ret_pc_load", 32'(bus.pc_load), 1);
    chk("ret_pc_out", bus.pc_out, 32'h0001_2345);
    cyc();

    // INT pc=0x100 flags=101 with request changed mid-sequence, then RTI
    drive(1'b1, OP_INT, 1'b0, 16'h0, 16'h0, 32'h0000_0100, 3'b101);
    exp_push(16'h0000);
    exp_push(16'h0100);
    exp_push(16'h0005);
    #1;
    chk("int_c1_stall", 32'(bus.stall), 1);
    cyc();
    drive(1'b1, OP_PUSH, 1'b0, 16'h0, 16'hFFFF, 32'hCAFE_F00D, 3'b010);
    #1;
    chk("int_c2_stall", 32'(bus.stall), 1);
    cyc();
    #1;
    chk("int_c3_stall", 32'(bus.stall), 0);
    cyc();
    drive(1'b1, OP_INT, 1'b1, 16'h0, 16'h0, 32'h0, 3'h0);
    exp_pop();
    exp_pop();
    exp_pop();
    exp_pc_flags(32'h0000_0100, 3'b101);
    #1;
    chk("rti_c1_stall", 32'(bus.stall), 1);
    cyc();
    #1;
    chk("rti_c2_stall", 32'(bus.stall), 1);
    cyc();
    #1;
    chk("rti_c3_stall", 32'(bus.stall), 0);
    cyc();
    idle();
    #1;
    chk("rti_pulses", 32'({bus.pc_load, bus.flags_load}), 32'b11);
    chk("rti_pc_out", bus.pc_out, 32'h0000_0100);
    chk("rti_flags_out", 32'(bus.flags_out), 32'b101);
    cyc();

    // reset during INT_LO
    stk_before = stk.size();
    drive(1'b1, OP_INT, 1'b0, 16'h0, 16'h0, 32'h0000_0200, 3'b011);
    exp_push(16'h0000);
    cyc();
    rst = 1'b1;
    #1;
    chk("rstmid_strobes", 32'({bus.memory_read, bus.memory_write, bus.memory_push, bus.memory_pop}), 0);
    chk("rstmid_stall", 32'(bus.stall), 0);
    cyc();
    rst = 1'b0;
    idle();
    repeat (4) cyc();
    chk("rstmid_stack_depth", 32'(stk.size()), 32'(stk_before + 1));
    chk("rstmid_stack_top", 32'(stk_top), 0);

    chk("strobe_queue_empty", 32'(exp_s.size()), 0);
    chk("pulse_queue_empty", 32'(exp_o.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
